// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port video RAM between the ULA video
// fetch, the CPU and the DMA/snapshot loader.
//
// Issue stage: one access per clk_sys is chosen from the requests visible
// in the current cycle and registered onto ram_*. Response stage: one clk
// later the read data is captured and the matching valid/ack pulse issued.
//
// Priority: video > promoted DMA > CPU > DMA. DMA is promoted above the CPU
// once dma_wait has reached DMA_MAX_WAIT consecutive denied cycles.
//
// Handshake: vid_req is a one-clock strobe, answered by a one-clock
// vid_valid two clocks later. cpu_req/dma_req are levels held until the
// matching *_ack pulse; the requester changes or drops req on the edge after
// it sees ack, so a requester is blocked both in the cycle after its issue
// and in the cycle its ack is visible.
//
// Optional feature: define VRAM_ARB_SNOW_EN to enable ULA snow. Video
// accesses issued while snow_ena=1 and the CPU requests the 01 address
// quarter then take address bits [6:0] from the CPU address.

module vram_arbiter #(
    parameter int AW           = 15,
    parameter int DW           = 8,
    parameter int DMA_MAX_WAIT = 15
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_dout,
    output logic          vid_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_ack,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_din,
    output logic [DW-1:0] dma_dout,
    output logic          dma_ack,
    input  logic          snow_ena,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    // Access source, used both for the grant and for the in-flight access.
    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_VID  = 2'd1;
    localparam logic [1:0] SRC_CPU  = 2'd2;
    localparam logic [1:0] SRC_DMA  = 2'd3;

    localparam logic [7:0] WAIT_MAX = 8'(DMA_MAX_WAIT);

    logic [1:0]    grant;          // source chosen this cycle
    logic [1:0]    inflight_src;   // source issued on the last edge
    logic          inflight_we;    // in-flight access is a write
    logic [7:0]    dma_wait;       // consecutive cycles DMA was denied
    logic          vid_pend;       // video read in flight, data next edge
    logic          cpu_elig;
    logic          dma_elig;
    logic          dma_promoted;
    logic [AW-1:0] vid_issue_addr;

    assign vid_pend = (inflight_src == SRC_VID);

    // A requester is blocked in the cycle after its issue and while its ack shows.
    assign cpu_elig     = cpu_req && (inflight_src != SRC_CPU) && !cpu_ack;
    assign dma_elig     = dma_req && (inflight_src != SRC_DMA) && !dma_ack;
    assign dma_promoted = dma_elig && (dma_wait == WAIT_MAX);

`ifdef VRAM_ARB_SNOW_EN
    // Video address, with the low bits replaced by the CPU address during snow.
    always_comb begin
        vid_issue_addr = vid_addr;
        if (snow_ena && cpu_req && (cpu_addr[AW-1:AW-2] == 2'b01)) begin
            vid_issue_addr[6:0] = cpu_addr[6:0];
        end
    end
`else
    logic unused_snow;
    assign unused_snow = snow_ena;

    // Video address passes through unaltered when snow is not built in.
    always_comb begin
        vid_issue_addr = vid_addr;
    end
`endif

    // Fixed-priority grant: video, promoted DMA, CPU, DMA.
    always_comb begin
        grant = SRC_NONE;
        if (vid_req) begin
            grant = SRC_VID;
        end else if (dma_promoted) begin
            grant = SRC_DMA;
        end else if (cpu_elig) begin
            grant = SRC_CPU;
        end else if (dma_elig) begin
            grant = SRC_DMA;
        end
    end

    // Issue stage: register the granted access onto the RAM port.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ram_addr     <= '0;
            ram_we       <= 1'b0;
            ram_din      <= '0;
            inflight_src <= SRC_NONE;
            inflight_we  <= 1'b0;
        end else begin
            ram_we       <= 1'b0;
            inflight_src <= grant;
            inflight_we  <= 1'b0;
            case (grant)
                SRC_VID: begin
                    ram_addr <= vid_issue_addr;
                end
                SRC_CPU: begin
                    ram_addr    <= cpu_addr;
                    ram_we      <= cpu_we;
                    inflight_we <= cpu_we;
                    if (cpu_we) begin
                        ram_din <= cpu_din;
                    end
                end
                SRC_DMA: begin
                    ram_addr    <= dma_addr;
                    ram_we      <= dma_we;
                    inflight_we <= dma_we;
                    if (dma_we) begin
                        ram_din <= dma_din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Response stage: capture read data and pulse the requester's valid/ack.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vid_dout  <= '0;
            vid_valid <= 1'b0;
            cpu_dout  <= '0;
            cpu_ack   <= 1'b0;
            dma_dout  <= '0;
            dma_ack   <= 1'b0;
        end else begin
            vid_valid <= (inflight_src == SRC_VID);
            cpu_ack   <= (inflight_src == SRC_CPU);
            dma_ack   <= (inflight_src == SRC_DMA);
            if (inflight_src == SRC_VID) begin
                vid_dout <= ram_dout;
            end
            if ((inflight_src == SRC_CPU) && !inflight_we) begin
                cpu_dout <= ram_dout;
            end
            if ((inflight_src == SRC_DMA) && !inflight_we) begin
                dma_dout <= ram_dout;
            end
        end
    end

    // Anti-starvation counter: counts denied DMA cycles, saturating.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dma_wait <= 8'd0;
        end else if (!dma_req || (grant == SRC_DMA)) begin
            dma_wait <= 8'd0;
        end else if (dma_wait != WAIT_MAX) begin
            dma_wait <= dma_wait + 8'd1;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed test-plan cases followed by randomized traffic,
// all checked every cycle against a transaction-level reference model.

module tb_vram_arbiter;

    localparam int AW   = 15;
    localparam int DW   = 8;
    localparam int MAXW = 3;

    // ---------------- clock / reset ----------------
    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    logic          vid_req = 1'b0, cpu_req = 1'b0, dma_req = 1'b0;
    logic          cpu_we = 1'b0, dma_we = 1'b0, snow_ena = 1'b0;
    logic [AW-1:0] vid_addr = '0, cpu_addr = '0, dma_addr = '0;
    logic [DW-1:0] cpu_din = '0, dma_din = '0;
    logic [DW-1:0] vid_dout, cpu_dout, dma_dout, ram_din, ram_dout;
    logic          vid_valid, cpu_ack, dma_ack, ram_we;
    logic [AW-1:0] ram_addr;

    vram_arbiter #(.AW(AW), .DW(DW), .DMA_MAX_WAIT(MAXW)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_valid(vid_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
        .dma_dout(dma_dout), .dma_ack(dma_ack),
        .snow_ena(snow_ena),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // RAM seen by the DUT: asynchronous read, written after each edge.
    logic [DW-1:0] vram [0:(1<<AW)-1];
    assign ram_dout = vram[ram_addr];

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Accesses are tracked as transactions with the cycle they were issued in.
    localparam int VID = 1, CPU = 2, DMA = 3;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            cyc = 0;
    int            cpu_last = -100, dma_last = -100, m_wait = 0;
    int            op_src = 0;
    bit            op_we = 1'b0;
    logic [AW-1:0] op_addr = '0;
    logic [DW-1:0] op_din = '0;
    logic [AW-1:0] e_ram_addr = '0;
    bit            e_ram_we = 1'b0, e_vid_valid = 1'b0, e_cpu_ack = 1'b0, e_dma_ack = 1'b0;
    logic [DW-1:0] e_ram_din = '0, e_vid_dout = '0, e_cpu_dout = '0, e_dma_dout = '0;

    task automatic model_edge();
        int pick;
        bit cpu_ok, dma_ok;
        logic [AW-1:0] va;
        if (op_src != 0 && op_we) mem[op_addr] = op_din;
        if (reset) begin
            e_ram_addr = '0; e_ram_we = 0; e_ram_din = '0;
            e_vid_valid = 0; e_cpu_ack = 0; e_dma_ack = 0;
            e_vid_dout = '0; e_cpu_dout = '0; e_dma_dout = '0;
            op_src = 0; op_we = 0; cpu_last = -100; dma_last = -100; m_wait = 0;
        end else begin
            // response to the access issued one cycle ago
            e_vid_valid = (op_src == VID);
            e_cpu_ack   = (op_src == CPU);
            e_dma_ack   = (op_src == DMA);
            if (op_src == VID) e_vid_dout = mem[op_addr];
            if (op_src == CPU && !op_we) e_cpu_dout = mem[op_addr];
            if (op_src == DMA && !op_we) e_dma_dout = mem[op_addr];
            // a held request may be granted at most once every three cycles
            cpu_ok = cpu_req && (cyc - cpu_last >= 3);
            dma_ok = dma_req && (cyc - dma_last >= 3);
            pick = 0;
            if (vid_req) pick = VID;
            else if (dma_ok && m_wait == MAXW) pick = DMA;
            else if (cpu_ok) pick = CPU;
            else if (dma_ok) pick = DMA;
            m_wait = (!dma_req || pick == DMA) ? 0 : ((m_wait < MAXW) ? m_wait + 1 : MAXW);
            e_ram_we = 0; op_src = pick; op_we = 0;
            if (pick == VID) begin
                va = vid_addr;
`ifdef VRAM_ARB_SNOW_EN
                if (snow_ena && cpu_req && cpu_addr[AW-1:AW-2] == 2'b01) va[6:0] = cpu_addr[6:0];
`endif
                e_ram_addr = va; op_addr = va;
            end else if (pick == CPU) begin
                e_ram_addr = cpu_addr; e_ram_we = cpu_we; op_we = cpu_we;
                op_addr = cpu_addr; op_din = cpu_din; cpu_last = cyc;
                if (cpu_we) e_ram_din = cpu_din;
            end else if (pick == DMA) begin
                e_ram_addr = dma_addr; e_ram_we = dma_we; op_we = dma_we;
                op_addr = dma_addr; op_din = dma_din; dma_last = cyc;
                if (dma_we) e_ram_din = dma_din;
            end
        end
        cyc++;
    endtask

    // ---------------- driver ----------------
    // One clock: advance the model, let the edge pass, update the RAM, compare.
    task automatic step();
        bit            w_en;
        logic [AW-1:0] w_a;
        logic [DW-1:0] w_d;
        w_en = (ram_we === 1'b1); w_a = ram_addr; w_d = ram_din;
        model_edge();
        @(posedge clk_sys);
        #1;
        if (w_en) vram[w_a] = w_d;
        check("ram_addr", 32'(ram_addr), 32'(e_ram_addr));
        check("ram_we", 32'(ram_we), 32'(e_ram_we));
        check("ram_din", 32'(ram_din), 32'(e_ram_din));
        check("vid_valid", 32'(vid_valid), 32'(e_vid_valid));
        check("vid_dout", 32'(vid_dout), 32'(e_vid_dout));
        check("cpu_ack", 32'(cpu_ack), 32'(e_cpu_ack));
        check("cpu_dout", 32'(cpu_dout), 32'(e_cpu_dout));
        check("dma_ack", 32'(dma_ack), 32'(e_dma_ack));
        check("dma_dout", 32'(dma_dout), 32'(e_dma_dout));
        check("dma_wait", 32'(dut.dma_wait), 32'(m_wait));
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [1:0] top;
        logic [3:0] low;
        top = 2'($urandom_range(0, 3));
        low = 4'($urandom_range(0, 15));
        return {top, 9'h000, low};
    endfunction

    task automatic new_cpu();
        cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = rand_addr(); cpu_din = 8'($urandom_range(0, 255));
    endtask

    task automatic new_dma();
        dma_req = 1; dma_we = 1'($urandom_range(0, 1));
        dma_addr = rand_addr(); dma_din = 8'($urandom_range(0, 255));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit cpu_ack_d, dma_ack_d;
        logic [AW-1:0] snow_exp;
        for (int i = 0; i < (1 << AW); i++) begin
            vram[i] = 8'(i * 7 + 3);
            mem[i]  = 8'(i * 7 + 3);
        end
        vram[15'h1800] = 8'hA5;
        mem[15'h1800]  = 8'hA5;

        // reset state
        reset = 1; step(); step();
        check("rst_ram_we", 32'(ram_we), 32'h0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'h0);
        reset = 0; step();

        // video only
        vid_req = 1; vid_addr = 15'h1800; step();
        check("vid_issue_addr", 32'(ram_addr), 32'h1800);
        vid_req = 0; step();
        check("vid_valid_t2", 32'(vid_valid), 32'h1);
        check("vid_dout_t2", 32'(vid_dout), 32'hA5);
        step();
        check("vid_single_pulse", 32'(vid_valid), 32'h0);

        // CPU write then read
        cpu_req = 1; cpu_we = 1; cpu_addr = 15'h0100; cpu_din = 8'h3C; step();
        check("cpu_wr_we", 32'(ram_we), 32'h1);
        step();
        check("cpu_wr_ack", 32'(cpu_ack), 32'h1);
        check("cpu_wr_we_1clk", 32'(ram_we), 32'h0);
        step();
        cpu_we = 0; step(); step();
        check("cpu_rd_ack", 32'(cpu_ack), 32'h1);
        check("cpu_rd_data", 32'(cpu_dout), 32'h3C);
        step();
        cpu_req = 0; step();

        // collision: video and CPU together
        vid_req = 1; vid_addr = 15'h1800; cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0100; step();
        check("coll_vid_first", 32'(ram_addr), 32'h1800);
        vid_req = 0; step();
        check("coll_vid_valid", 32'(vid_valid), 32'h1);
        check("coll_cpu_second", 32'(ram_addr), 32'h0100);
        step();
        check("coll_cpu_ack", 32'(cpu_ack), 32'h1);
        step();
        cpu_req = 0; step();

        // starvation guard
        dma_req = 1; dma_we = 1; dma_addr = 15'h0200; dma_din = 8'h77;
        cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0100;
        for (int i = 0; i < 4; i++) begin
            vid_req = 1; vid_addr = 15'(15'h1800 + i); step();
        end
        check("starve_wait_sat", 32'(dut.dma_wait), 32'd3);
        vid_req = 0; step();
        check("starve_dma_first", 32'(ram_addr), 32'h0200);
        check("starve_wait_clr", 32'(dut.dma_wait), 32'd0);
        step();
        check("starve_cpu_next", 32'(ram_addr), 32'h0100);
        step();
        dma_req = 0; step();
        cpu_req = 0; step();

        // reset mid-access
        cpu_req = 1; cpu_we = 0; cpu_addr = 15'h1800; step();
        reset = 1; cpu_req = 0; step();
        check("rst_mid_no_ack", 32'(cpu_ack), 32'h0);
        check("rst_mid_addr", 32'(ram_addr), 32'h0);
        check("rst_mid_cpu_dout", 32'(cpu_dout), 32'h0);
        reset = 0; step();

        // snow
`ifdef VRAM_ARB_SNOW_EN
        snow_exp = 15'h18D5;
`else
        snow_exp = 15'h1880;
`endif
        snow_ena = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 15'h2055;
        vid_req = 1; vid_addr = 15'h1880; step();
        check("snow_addr", 32'(ram_addr), 32'(snow_exp));
        vid_req = 0; step(); step(); step();
        cpu_req = 0; snow_ena = 0; step();

        // randomized traffic
        cpu_ack_d = 0; dma_ack_d = 0;
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            vid_req  = ($urandom_range(0, 3) == 0);
            vid_addr = rand_addr();
            snow_ena = 1'($urandom_range(0, 1));
            if (cpu_ack_d) begin
                if ($urandom_range(0, 1) == 1) new_cpu(); else cpu_req = 0;
            end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
                new_cpu();
            end
            if (dma_ack_d) begin
                if ($urandom_range(0, 1) == 1) new_dma(); else dma_req = 0;
            end else if (!dma_req && $urandom_range(0, 2) == 0) begin
                new_dma();
            end
            cpu_ack_d = e_cpu_ack;
            dma_ack_d = e_dma_ack;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
